// File: rtl/sm_bus_arbiter_if.sv
// rtl/sm_bus_arbiter_if.sv - bus bundle between two masters, the arbiter and the peripheral bus
//
// Carries both master request channels and the single peripheral bus.
//   m0_*/m1_*  : req, addr, we, wdata toward the arbiter; ack, rdata back
//   s_*        : addr, we, wdata toward the peripheral; rdata back
// Modports:
//   master : the arbiter, which owns the peripheral bus and answers the masters
//   slave  : everything around the arbiter (requesting masters and the peripheral)
interface sm_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              m0_req;
  logic              m1_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic              m0_we;
  logic              m1_we;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_ack;
  logic              m1_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] s_addr;
  logic              s_we;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, s_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, s_addr, s_we, s_wdata
  );

  modport slave (
    output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, s_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, s_addr, s_we, s_wdata
  );
endinterface

// File: rtl/sm_bus_arbiter.sv
// rtl/sm_bus_arbiter.sv - two-master, single-slave peripheral bus arbiter
//
// Serialises accesses from master 0 (CPU data) and master 1 (debug/DMA) onto one
// peripheral bus whose slave returns read data one edge after the address.
// Each transaction walks IDLE -> ADDR -> DATA -> ACK; the bus address is parked
// at PARK_ADDR outside ADDR so no peripheral decodes a stray access.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : sm_bus_arbiter_if.master (m0_*/m1_* request channels, s_* peripheral bus)
// Build option: define SM_BUS_ARB_FIXED_PRIO_EN for fixed priority (m0 always wins
// contention); otherwise contended grants alternate round robin.
module sm_bus_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] PARK_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  sm_bus_arbiter_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  logic [1:0]        state;
  logic              gnt;
  logic              win;
  logic [ADDR_W-1:0] s_addr_q;
  logic              s_we_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

`ifdef SM_BUS_ARB_FIXED_PRIO_EN
  // m1 only gets the bus when m0 is not asking for it.
  always_comb begin
    win = ~bus.m0_req;
  end
`else
  // Master granted most recently; reset to 1 so m0 takes the first contended grant.
  logic last;

  always_comb begin
    if (bus.m0_req && bus.m1_req) begin
      win = ~last;
    end else begin
      win = bus.m1_req;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= 1'b0;
      s_addr_q   <= PARK_ADDR;
      s_we_q     <= 1'b0;
      s_wdata_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifndef SM_BUS_ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Master inputs are sampled only here; later changes wait for the next grant.
          if (bus.m0_req || bus.m1_req) begin
            gnt       <= win;
`ifndef SM_BUS_ARB_FIXED_PRIO_EN
            last      <= win;
`endif
            s_addr_q  <= win ? bus.m1_addr  : bus.m0_addr;
            s_we_q    <= win ? bus.m1_we    : bus.m0_we;
            s_wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // Access is presented for exactly one cycle; wdata is left as is.
          s_addr_q <= PARK_ADDR;
          s_we_q   <= 1'b0;
          state    <= ST_DATA;
        end
        ST_DATA: begin
          // Slave read data is valid now; captured for writes too.
          if (gnt) begin
            m1_rdata_q <= bus.s_rdata;
            m1_ack_q   <= 1'b1;
          end else begin
            m0_rdata_q <= bus.s_rdata;
            m0_ack_q   <= 1'b1;
          end
          state <= ST_ACK;
        end
        ST_ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_addr   = s_addr_q;
  assign bus.s_we     = s_we_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

endmodule
